// File: rtl/fibonacci_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// fibonacci_scheduler_pkg
//
// Shared types and constants for the Fibonacci scheduler slice.
//   NUM_W         : width of the Fibonacci result datapath (16 bits).
//   CALC_W        : internal adder width. Two guard bits hold the carry out of
//                   a+b and a+2b, whose operands are each below 2^16.
//   num_t         : one Fibonacci value, truncated to NUM_W bits.
//   sched_state_t : top-level controller states.
//   widen()       : zero-extends a num_t to CALC_W bits before an addition.
// -----------------------------------------------------------------------------
package fibonacci_scheduler_pkg;

    localparam int NUM_W  = 16;
    localparam int CALC_W = NUM_W + 2;

    typedef logic [NUM_W-1:0] num_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    function automatic logic [CALC_W-1:0] widen(input num_t x);
        return {2'b00, x};
    endfunction

endpackage

// File: rtl/fib_step_core.sv
// -----------------------------------------------------------------------------
// fib_step_core
//
// Fibonacci stepping datapath. The pair (a, b) holds (F(k), F(k+1)) modulo
// 2^NUM_W, and ovf_a / ovf_b record whether the true value has ever reached
// 2^NUM_W.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, clears all state
//   load   in   start a new sequence: a=F(0)=0, b=F(1)=1, flags cleared
//   step1  in   advance one step:  (a, b) <- (b, a+b)
//   step2  in   advance two steps: (a, b) <- (a+b, a+2b)
//   a      out  current F(k), truncated
//   ovf_a  out  true F(k) is >= 2^NUM_W
//
// load, step1 and step2 are mutually exclusive. If several are raised anyway,
// load wins over step2, and step2 wins over step1.
// -----------------------------------------------------------------------------
module fib_step_core
    import fibonacci_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step1,
    input  logic step2,
    output num_t a,
    output logic ovf_a
);

    num_t              b;
    logic              ovf_b;

    logic [CALC_W-1:0] sum_ab;
    logic [CALC_W-1:0] sum_a2b;
    logic              carry_ab;
    logic              carry_a2b;
    logic              ovf_any;

    // a+2b is formed as (a+b)+b. The result stays below 3*2^16, so the two
    // guard bits are enough. Anything above the low NUM_W bits is the carry.
    always_comb begin
        sum_ab    = widen(a) + widen(b);
        sum_a2b   = sum_ab + widen(b);
        carry_ab  = |sum_ab[CALC_W-1:NUM_W];
        carry_a2b = |sum_a2b[CALC_W-1:NUM_W];
        ovf_any   = ovf_a | ovf_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
        end else if (load) begin
            a     <= '0;
            b     <= num_t'(1);
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
        end else if (step2) begin
            a     <= sum_ab[NUM_W-1:0];
            b     <= sum_a2b[NUM_W-1:0];
            ovf_a <= ovf_any | carry_ab;
            ovf_b <= ovf_any | carry_a2b;
        end else if (step1) begin
            a     <= b;
            b     <= sum_ab[NUM_W-1:0];
            ovf_a <= ovf_b;
            ovf_b <= ovf_any | carry_ab;
        end
    end

endmodule

// File: rtl/fibonacci_scheduler.sv
// -----------------------------------------------------------------------------
// fibonacci_scheduler
//
// Shares one double-rate Fibonacci datapath between N_REQ requesters.
// Requests are granted round-robin and processed one at a time. Each request
// returns F(n) mod 2^16 and an overflow flag.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   IDX_W  index width; legal n is 0 .. 2^IDX_W-1
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_vld    in   [N_REQ]        request valid, one bit per requester
//   req_rdy    out  [N_REQ]        request accept, one-hot or zero
//   req_idx    in   [N_REQ*IDX_W]  requester i uses bits [i*IDX_W +: IDX_W]
//   rsp_vld    out                 response valid
//   rsp_rdy    in                  response accept
//   rsp_id     out  [ID_W]         requester the response belongs to
//   rsp_num    out  [16]           F(n) mod 2^16
//   rsp_ovf    out                 true F(n) >= 2^16
//   busy       out                 high in RUN or RESP
//   dbg_state  out                 current controller state, for observation
//
// Handshake semantics, for both the request and the response side: a transfer
// happens in a cycle where valid and ready are both high at the rising edge.
// A producer that raises valid must hold valid and its payload unchanged until
// that transfer. Ready may depend combinationally on valid; valid never depends
// on ready. The request side drives req_rdy combinationally, so the accept
// happens in the same cycle. The response side registers rsp_vld and its
// payload, so they stay stable during backpressure.
// -----------------------------------------------------------------------------
module fibonacci_scheduler
    import fibonacci_scheduler_pkg::*;
#(
    parameter  int N_REQ = 2,
    parameter  int IDX_W = 5,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_vld,
    output logic [N_REQ-1:0]       req_rdy,
    input  logic [N_REQ*IDX_W-1:0] req_idx,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [ID_W-1:0]        rsp_id,
    output num_t                   rsp_num,
    output logic                   rsp_ovf,
    output logic                   busy,
    output sched_state_t           dbg_state
);

    localparam logic [IDX_W-1:0] REM_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] REM_TWO = IDX_W'(2);

    sched_state_t     state;
    sched_state_t     state_nxt;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [IDX_W-1:0] rem;
    logic [ID_W-1:0]  id;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic [IDX_W-1:0] grant_idx;

    logic             core_load;
    logic             core_step1;
    logic             core_step2;
    logic             rsp_load;

    num_t             fib_a;
    logic             fib_ovf_a;

    // -------------------------------------------------------------------------
    // Round-robin arbiter. The search starts at ptr and wraps around, so the
    // requester just served has the lowest priority next time.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            int              cand_int;
            logic [ID_W-1:0] cand;
            cand_int = (int'(ptr) + off) % N_REQ;
            cand     = cand_int[ID_W-1:0];
            if (!grant_vld && req_vld[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        int nxt_int;
        nxt_int   = (int'(grant_id) + 1) % N_REQ;
        ptr_nxt   = nxt_int[ID_W-1:0];
        grant_idx = req_idx[int'(grant_id)*IDX_W +: IDX_W];
    end

    // -------------------------------------------------------------------------
    // Controller, next-state and output decode.
    // RUN spends one cycle per double step, or one for a final single step
    // when n is odd. It then spends one more cycle with rem == 0, which loads
    // the response registers. Because of this, rsp_vld appears
    // 2 + ceil(n/2) cycles after the accept.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        req_rdy    = '0;
        core_load  = 1'b0;
        core_step1 = 1'b0;
        core_step2 = 1'b0;
        rsp_load   = 1'b0;

        unique case (state)
            IDLE: begin
                // A grant is never offered during reset, so an accept cannot
                // happen in the same edge that clears the block.
                if (grant_vld && !rst) begin
                    req_rdy[grant_id] = 1'b1;
                    core_load         = 1'b1;
                    state_nxt         = RUN;
                end
            end
            RUN: begin
                if (rem >= REM_TWO) begin
                    core_step2 = 1'b1;
                end else if (rem == REM_ONE) begin
                    core_step1 = 1'b1;
                end else begin
                    rsp_load  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_vld && rsp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, round-robin pointer, request bookkeeping, response registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            rem     <= '0;
            id      <= '0;
            rsp_vld <= 1'b0;
            rsp_num <= '0;
            rsp_id  <= '0;
            rsp_ovf <= 1'b0;
        end else begin
            state <= state_nxt;

            if (core_load) begin
                rem <= grant_idx;
                id  <= grant_id;
                ptr <= ptr_nxt;
            end else if (core_step2) begin
                rem <= rem - REM_TWO;
            end else if (core_step1) begin
                rem <= rem - REM_ONE;
            end

            // The payload registers are written only when the response is
            // created, so they hold their value through any rsp_rdy stall.
            if (rsp_load) begin
                rsp_vld <= 1'b1;
                rsp_num <= fib_a;
                rsp_ovf <= fib_ovf_a;
                rsp_id  <= id;
            end else if (rsp_vld && rsp_rdy) begin
                rsp_vld <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    fib_step_core u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (core_load),
        .step1 (core_step1),
        .step2 (core_step2),
        .a     (fib_a),
        .ovf_a (fib_ovf_a)
    );

endmodule

// File: tb/tb_fibonacci_scheduler.sv
module tb_fibonacci_scheduler;
    import fibonacci_scheduler_pkg::*;

    localparam int N_REQ = 2;
    localparam int IDX_W = 5;
    localparam int ID_W  = $clog2(N_REQ);

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ-1:0]       req_rdy;
    logic [N_REQ*IDX_W-1:0] req_idx;
    logic                   rsp_vld;
    logic                   rsp_rdy;
    logic [ID_W-1:0]        rsp_id;
    num_t                   rsp_num;
    logic                   rsp_ovf;
    logic                   busy;
    sched_state_t           dbg_state;

    fibonacci_scheduler #(.N_REQ(N_REQ), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_idx   (req_idx),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_id    (rsp_id),
        .rsp_num   (rsp_num),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: round-robin pointer, per-requester index,
    // expected-result queue.
    int          mdl_ptr;
    int          cur_n[N_REQ];
    logic [31:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // True (untruncated) Fibonacci value, F(0)=0, F(1)=1.
    function automatic longint fib_true(input int n);
        longint f0, f1, t;
        f0 = 0;
        f1 = 1;
        for (int i = 0; i < n; i++) begin
            t  = f0 + f1;
            f0 = f1;
            f1 = t;
        end
        return f0;
    endfunction

    // First set bit of mask, searching upward from mdl_ptr with wrap-around.
    function automatic int pick(input logic [N_REQ-1:0] mask);
        for (int off = 0; off < N_REQ; off++) begin
            int j;
            j = (mdl_ptr + off) % N_REQ;
            if (mask[j]) return j;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        req_vld = '0;
        rsp_rdy = 1'b0;
        repeat (3) tick();
        rst     = 1'b0;
        mdl_ptr = 0;
        exp_q.delete();
    endtask

    // ---------------- driver + scoreboard for one transaction ----------------
    task automatic serve(input logic [N_REQ-1:0] mask, input int stall, input bit hold);
        int          g, n, w, lat;
        longint      f;
        logic [31:0] exp_num, exp_ovf;
        num_t        held;

        req_vld = mask;
        for (int i = 0; i < N_REQ; i++) req_idx[i*IDX_W +: IDX_W] = IDX_W'(cur_n[i]);
        #1;
        w = 0;
        while (req_rdy == '0 && w < 40) begin
            tick();
            w++;
        end
        g = pick(mask);
        chk("grant", 32'(req_rdy), 32'(1 << g));
        if (req_rdy == '0) return;

        n       = cur_n[g];
        f       = fib_true(n);
        exp_num = 32'(f % 65536);
        exp_ovf = (f >= 65536) ? 32'd1 : 32'd0;
        exp_q.push_back(exp_num);
        mdl_ptr = (g + 1) % N_REQ;

        tick();
        if (!hold) req_vld[g] = 1'b0;
        #1;
        chk("busy_run", 32'(busy), 32'd1);
        chk("rdy_in_run", 32'(req_rdy), 32'd0);

        lat = 1;
        while (!rsp_vld && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, 2 + (n + 1) / 2);
        chk("rsp_num", 32'(rsp_num), exp_q.pop_front());
        chk("rsp_ovf", 32'(rsp_ovf), exp_ovf);
        chk("rsp_id", 32'(rsp_id), g);

        held = rsp_num;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_vld", 32'(rsp_vld), 32'd1);
            chk("stall_num", 32'(rsp_num), exp_num);
            chk("stall_rdy", 32'(req_rdy), 32'd0);
        end
        if (stall > 0) chk("stall_hold", 32'(rsp_num), 32'(held));

        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk("post_hs_vld", 32'(rsp_vld), 32'd0);
        chk("post_hs_idle", 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int cnt;
        rst     = 1'b1;
        req_vld = '0;
        req_idx = '0;
        rsp_rdy = 1'b0;
        for (int i = 0; i < N_REQ; i++) cur_n[i] = 0;

        do_reset();
        chk("reset_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("reset_rsp_num", 32'(rsp_num), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));

        // Single requester 0, n=10.
        cur_n[0] = 10;
        serve(2'b01, 0, 1'b0);

        // Sweep every index on requester 1.
        for (int n = 0; n < 32; n++) begin
            cur_n[1] = n;
            serve(2'b10, 0, 1'b0);
        end

        // Both requesters held continuously: grants alternate from 0.
        do_reset();
        cur_n[0] = 3;
        cur_n[1] = 4;
        for (int k = 0; k < 4; k++) serve(2'b11, 0, 1'b1);
        req_vld = '0;

        // Backpressure on the response.
        cur_n[0] = 7;
        serve(2'b01, 5, 1'b0);

        // Reset three cycles into RUN drops the request.
        do_reset();
        req_idx[0 +: IDX_W] = IDX_W'(20);
        req_vld = 2'b01;
        #1;
        chk("rst_test_grant", 32'(req_rdy), 32'd1);
        tick();
        req_vld = '0;
        tick();
        tick();
        rst     = 1'b1;
        req_vld = 2'b10;
        #1;
        chk("rdy_in_reset", 32'(req_rdy), 32'd0);
        tick();
        chk("mid_rst_vld", 32'(rsp_vld), 32'd0);
        chk("mid_rst_num", 32'(rsp_num), 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_ovf", 32'(rsp_ovf), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rdy", 32'(req_rdy), 32'd0);
        rst     = 1'b0;
        req_vld = '0;
        mdl_ptr = 0;
        cnt     = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_vld) cnt++;
        end
        chk("no_rsp_after_rst", cnt, 0);
        cur_n[0] = 5;
        serve(2'b01, 0, 1'b0);

        // Only requester 1 while ptr=0, then a simultaneous request goes to 0.
        do_reset();
        cur_n[1] = 6;
        serve(2'b10, 0, 1'b0);
        cur_n[0] = 8;
        serve(2'b11, 1, 1'b0);
        req_vld = '0;
        tick();

        // Random traffic.
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N_REQ; i++) cur_n[i] = $urandom_range(0, 31);
            serve(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), $urandom_range(0, 3), 1'b0);
            req_vld = '0;
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fibonacci_scheduler.md
# fibonacci_scheduler

Shares one double-rate 16-bit Fibonacci stepping datapath between `N_REQ` requesters. Each request carries an index `n` and returns F(n), with F(0)=0 and F(1)=F(2)=1, truncated to 16 bits, plus an overflow flag. Requests are granted round-robin and processed one at a time, advancing two Fibonacci steps per cycle. The block sits between request-producing clients and a single response consumer.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters; legal range is 2..8.
- `IDX_W`, 5: index width; legal n is 0..2^IDX_W−1.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_vld`  in  N_REQ  request valid, one bit per requester.
- `req_rdy`  out  N_REQ  request accept, one-hot or zero.
- `req_idx`  in  N_REQ*IDX_W  packed indices; requester i uses bits [i*IDX_W +: IDX_W].
- `rsp_vld`  out  1  response valid.
- `rsp_rdy`  in  1  response accept.
- `rsp_id`  out  $clog2(N_REQ)  requester number the response belongs to.
- `rsp_num`  out  16  F(n) mod 2^16.
- `rsp_ovf`  out  1  set when the true F(n) is ≥ 2^16.
- `busy`  out  1  high in RUN or RESP.

## Operation
- State machine with three states:
  - IDLE → RUN when any `req_vld` bit is high.
  - RUN → RESP when `rem` == 0.
  - RESP → IDLE on `rsp_vld` && `rsp_rdy`.
- **Accept (IDLE):**
  - `req_rdy[g]` is driven combinationally, only in IDLE and not in reset, for the granted index g.
  - g is the first requester with `req_vld` set, searching from `ptr` upward with wrap-around.
  - On accept, latch `id`=g and `rem`=n, and load a=0, b=1, ovf_a=0, ovf_b=0.
  - Set `ptr`=(g+1) mod N_REQ. `ptr` resets to 0.
- **Step (RUN):** a holds F(k) and b holds F(k+1).
  - rem ≥ 2, double step: a←a+b, b←a+2b. Each flag ORs its operand flags with the carry out of its own addition, computed in 18 bits. rem←rem−2.
  - rem == 1, single step: a←b, b←a+b. ovf_a←ovf_b; ovf_b←ovf_a|ovf_b|carry. rem←rem−1.
  - rem == 0: no step; go to RESP.
- **RESP:**
  - `rsp_vld`=1, `rsp_num`=a, `rsp_ovf`=ovf_a, `rsp_id`=id.
  - All four outputs are registered and held stable until the handshake.
- One request is in flight at a time. `req_rdy` is all-zero in RUN and RESP.
- Requesters must hold `req_vld` and `req_idx` until accepted. The block does not check this.
- **Reset** (any state, including mid-RUN or during RESP stall):
  - The in-flight request is dropped and no response is produced.
  - State returns to IDLE.
  - `rsp_vld`, `rsp_num`, `rsp_id`, `rsp_ovf`, `busy` and `req_rdy` are all 0.

## Timing
- Accept at cycle T, where `req_vld[g]` && `req_rdy[g]` are both high. RUN occupies cycles T+1 .. T+1+ceil(n/2).
- `rsp_vld` rises at cycle T+2+ceil(n/2):
  - n=0 → T+2
  - n=1 → T+3
  - n=10 → T+7
  - n=31 → T+18
- A handshake in cycle R returns the block to IDLE at R+1. The earliest next accept is R+1.
- Requests asserted during RUN or RESP wait. There is no queuing beyond the requester's own hold.
- `rsp_rdy` held high gives a fixed per-request occupancy of ceil(n/2)+3 cycles.

## Structure
- Package `fibonacci_scheduler_pkg`:
  - `NUM_W`=16
  - state enum `sched_state_t` {IDLE, RUN, RESP}
  - typedef `num_t` = logic [NUM_W-1:0]
- Sub-module `fib_step_core`:
  - Holds a, b, ovf_a, ovf_b.
  - Inputs: `load`, `step1`, `step2`, mutually exclusive.
  - Outputs: a, ovf_a.
  - Owns all arithmetic and carry logic.
- The top level owns the FSM, the round-robin pointer, `rem`, `id` and the response registers.

## Test plan
- Single requester 0, n=10, `rsp_rdy`=1 → `rsp_num`=55, `rsp_ovf`=0, `rsp_id`=0, `rsp_vld` exactly 7 cycles after accept.
- Sweep n=0..31 on requester 1:
  - 0→0, 1→1, 2→1, 24→46368 with ovf=0.
  - 25→9489 with ovf=1.
  - 31→35549 with ovf=1.
  - Each latency matches 2+ceil(n/2).
- Both requesters hold `req_vld` continuously with n=3 and n=4 → grants alternate 0,1,0,1 starting at 0 after reset; responses are 2 then 3 with matching `rsp_id`.
- Backpressure: n=7, `rsp_rdy` held low 5 cycles after `rsp_vld` → `rsp_num`=13 stable, `rsp_vld` stays 1, `req_rdy`=0 throughout; IDLE one cycle after the handshake.
- Reset: assert `rst` 3 cycles into RUN for n=20 → all outputs 0 next cycle, no response; a fresh n=5 request then returns 5.
- Only requester 1 requesting while `ptr`=0 → granted immediately; `ptr` becomes 0 again (wrap), verified by a following simultaneous request being granted to 0.
